// File: rtl/regfile_multiport.sv
// regfile_multiport: NREGS x WIDTH register file with two combinational read ports,
// synchronous clear, optional write-through bypass and a per-register written flag.
module regfile_multiport #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int BYPASS = 0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic [NREGS-1:0] written
);
  logic [WIDTH-1:0] r_mem [NREGS];
  logic [NREGS-1:0] r_written;
  logic             w_wen;
  logic             w_hit_a;
  logic             w_hit_b;
  // Out-of-range register numbers exist when NREGS is not a power of two.
  always_comb begin
    w_wen      = write && !reset && (32'(writenum) < NREGS);
    w_hit_a    = (BYPASS != 0) && w_wen && (readnum_a == writenum);
    w_hit_b    = (BYPASS != 0) && w_wen && (readnum_b == writenum);
    data_out_a = w_hit_a ? data_in : ((32'(readnum_a) < NREGS) ? r_mem[readnum_a] : '0);
    data_out_b = w_hit_b ? data_in : ((32'(readnum_b) < NREGS) ? r_mem[readnum_b] : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem     <= '{default: '0};
      r_written <= '0;
    end else if (w_wen) begin
      r_mem[writenum]     <= data_in;
      r_written[writenum] <= 1'b1;
    end
  end
  assign written = r_written;
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: vector table for 8x16 (BYPASS 0 and 1 side by side) plus a
// hand sequence for a 6x32 instance with out-of-range register numbers.
module tb_regfile_multiport;
  logic        clk = 1'b0;
  logic        rst = 1'b0, wr = 1'b0;
  logic [2:0]  wn = '0, ra = '0, rb = '0;
  logic [15:0] din = '0;
  logic [15:0] a0, b0, a1, b1;
  logic [7:0]  wt0, wt1;
  logic        rst2 = 1'b0, w2 = 1'b0;
  logic [2:0]  wn2 = '0, ra2 = '0, rb2 = '0;
  logic [31:0] d2 = '0, oa2, ob2;
  logic [5:0]  wt2;
  int          n_chk = 0, n_err = 0;

  typedef struct {
    logic        rst, wr, pre;
    logic [2:0]  wn, ra, rb;
    logic [15:0] din, a0, b0, a1, b1, pa, pb;
    logic [7:0]  wt;
  } vec_t;
  vec_t        tv[$];
  logic [39:0] sb[$];

  always #5 clk = ~clk;

  regfile_multiport #(.WIDTH(16), .NREGS(8), .BYPASS(0)) u0 (
    .clk(clk), .reset(rst), .data_in(din), .writenum(wn), .write(wr),
    .readnum_a(ra), .readnum_b(rb), .data_out_a(a0), .data_out_b(b0), .written(wt0));
  regfile_multiport #(.WIDTH(16), .NREGS(8), .BYPASS(1)) u1 (
    .clk(clk), .reset(rst), .data_in(din), .writenum(wn), .write(wr),
    .readnum_a(ra), .readnum_b(rb), .data_out_a(a1), .data_out_b(b1), .written(wt1));
  regfile_multiport #(.WIDTH(32), .NREGS(6), .BYPASS(0)) u2 (
    .clk(clk), .reset(rst2), .data_in(d2), .writenum(wn2), .write(w2),
    .readnum_a(ra2), .readnum_b(rb2), .data_out_a(oa2), .data_out_b(ob2), .written(wt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic p, input logic [2:0] n,
                              input logic [15:0] d, input logic [2:0] x, input logic [2:0] y,
                              input logic [15:0] ea0, input logic [15:0] eb0,
                              input logic [15:0] ea1, input logic [15:0] eb1,
                              input logic [15:0] qa, input logic [15:0] qb, input logic [7:0] q);
    vec_t v;
    v.rst = r; v.wr = w; v.pre = p; v.wn = n; v.din = d; v.ra = x; v.rb = y;
    v.a0 = ea0; v.b0 = eb0; v.a1 = ea1; v.b1 = eb1; v.pa = qa; v.pb = qb; v.wt = q;
    return v;
  endfunction

  task automatic step(input vec_t v, input int idx);
    logic [39:0] e;
    @(negedge clk);
    rst = v.rst; wr = v.wr; wn = v.wn; din = v.din; ra = v.ra; rb = v.rb;
    sb.push_back({v.pa, v.pb, v.wt});
    #1;
    if (v.pre) begin
      chk($sformatf("v%0d pre_a bypass0", idx), a0, v.a0);
      chk($sformatf("v%0d pre_b bypass0", idx), b0, v.b0);
      chk($sformatf("v%0d pre_a bypass1", idx), a1, v.a1);
      chk($sformatf("v%0d pre_b bypass1", idx), b1, v.b1);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL v%0d scoreboard empty: got 0 entries expected 1", idx);
    end else begin
      n_chk--;
      e = sb.pop_front();
      chk($sformatf("v%0d post_a bypass0", idx), a0, e[39:24]);
      chk($sformatf("v%0d post_b bypass0", idx), b0, e[23:8]);
      chk($sformatf("v%0d post_a bypass1", idx), a1, e[39:24]);
      chk($sformatf("v%0d post_b bypass1", idx), b1, e[23:8]);
      chk($sformatf("v%0d written bypass0", idx), wt0, e[7:0]);
      chk($sformatf("v%0d written bypass1", idx), wt1, e[7:0]);
    end
  endtask

  initial begin
    tv.push_back(mk(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 8'h00));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(0, 1, 1, 3'(i), 16'h1000 + 16'(i), 3, 6,
                      i > 3 ? 16'h1003 : 16'h0, i > 6 ? 16'h1006 : 16'h0,
                      i >= 3 ? 16'h1003 : 16'h0, i >= 6 ? 16'h1006 : 16'h0,
                      i >= 3 ? 16'h1003 : 16'h0, i >= 6 ? 16'h1006 : 16'h0,
                      8'((9'd1 << (i + 1)) - 9'd1)));
    tv.push_back(mk(0, 1, 1, 2, 16'd38, 2, 5, 16'h1002, 16'h1005, 16'd38, 16'h1005, 16'd38, 16'h1005, 8'hFF));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 0, 1, 2, 16'd8, 2, 2, 16'd38, 16'd38, 16'd38, 16'd38, 16'd38, 16'd38, 8'hFF));
    tv.push_back(mk(0, 1, 1, 5, 16'd22, 5, 5, 16'h1005, 16'h1005, 16'd22, 16'd22, 16'd22, 16'd22, 8'hFF));
    tv.push_back(mk(0, 1, 1, 5, 16'd1100, 5, 5, 16'd22, 16'd22, 16'd1100, 16'd1100, 16'd1100, 16'd1100, 8'hFF));
    tv.push_back(mk(0, 1, 1, 4, 16'd2345, 4, 3, 16'h1004, 16'h1003, 16'd2345, 16'h1003, 16'd2345, 16'h1003, 8'hFF));
    tv.push_back(mk(1, 1, 1, 4, 16'hFFFF, 4, 3, 16'd2345, 16'h1003, 16'd2345, 16'h1003, 16'h0, 16'h0, 8'h00));
    tv.push_back(mk(0, 1, 1, 7, 16'hABCD, 7, 0, 16'h0, 16'h0, 16'hABCD, 16'h0, 16'hABCD, 16'h0, 8'h80));
    foreach (tv[i]) step(tv[i], i);
    @(negedge clk);
    wr = 1'b0;

    // 6x32 instance: register number 7 and 6 are out of range
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    chk("d6 reset written", 32'(wt2), 32'h0);
    @(negedge clk);
    rst2 = 1'b0; w2 = 1'b1; wn2 = 3'd7; d2 = 32'hDEADBEEF; ra2 = 3'd6; rb2 = 3'd7;
    #1;
    chk("d6 ra=6 zero", oa2, 32'h0);
    chk("d6 rb=7 zero", ob2, 32'h0);
    @(posedge clk);
    #1;
    chk("d6 oob write written", 32'(wt2), 32'h0);
    @(negedge clk);
    w2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra2 = 3'(i); rb2 = 3'(5 - i);
      #1;
      chk($sformatf("d6 R%0d after oob write", i), oa2, 32'h0);
    end
    w2 = 1'b1; wn2 = 3'd5; ra2 = 3'd5; rb2 = 3'd5;
    @(posedge clk);
    #1;
    chk("d6 R5 port a", oa2, 32'hDEADBEEF);
    chk("d6 R5 port b", ob2, 32'hDEADBEEF);
    chk("d6 R5 written", 32'(wt2), 32'h20);
    @(negedge clk);
    w2 = 1'b0; ra2 = 3'd6;
    #1;
    chk("d6 ra=6 zero after write", oa2, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
